// File: rtl/dma_hold_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dma_hold_controller
//  Description : Arbitrates system-bus ownership between an 8088 CPU and an
//                8237 DMA controller, and inserts programmable CPU wait states
//                through the READY line.
//
//  Ports
//    clock            in   system clock, one period per CPU T-state
//    reset            in   asynchronous, active-high reset
//    processor_status in   8088 S2:S0 (3'b111 = passive)
//    lock_n           in   CPU LOCK, low while the bus is locked
//    hold_request     in   HRQ from the 8237 (asynchronous)
//    io_channel_ready in   external I/O channel ready (asynchronous)
//    hold_acknowledge out  HLDA to the 8237
//    address_enable_n out  low while the CPU owns address/command bus
//    dma_enable_n     out  low while the DMA owns the address bus
//    cpu_ready        out  READY to the CPU, low inserts wait states
//    dma_ready        out  READY to the 8237
//
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_hold_controller #(
  parameter int unsigned IO_WAIT_STATES    = 1,
  parameter int unsigned MEM_WAIT_STATES   = 0,
  parameter int unsigned HOLD_SETUP_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] processor_status,
  input  logic       lock_n,
  input  logic       hold_request,
  input  logic       io_channel_ready,
  output logic       hold_acknowledge,
  output logic       address_enable_n,
  output logic       dma_enable_n,
  output logic       cpu_ready,
  output logic       dma_ready
);

  localparam logic [2:0] c_status_passive = 3'b111;
  localparam logic [2:0] c_io_wait        = 3'(IO_WAIT_STATES);
  localparam logic [2:0] c_mem_wait       = 3'(MEM_WAIT_STATES);
  localparam logic [2:0] c_setup_cycles   = 3'(HOLD_SETUP_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_IDLE = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_GRANT     = 3'd3,
    ST_RETURN    = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       hrq_meta_q, hrq_meta_d;
  logic       hrq_s_q, hrq_s_d;
  logic       rdy_meta_q, rdy_meta_d;
  logic       rdy_s_q, rdy_s_d;
  logic [2:0] status_prev_q, status_prev_d;
  logic [2:0] wait_count_q, wait_count_d;
  logic [2:0] setup_count_q, setup_count_d;
  logic       address_enable_n_q, address_enable_n_d;
  logic       dma_enable_n_q, dma_enable_n_d;
  logic       hold_acknowledge_q, hold_acknowledge_d;
  logic       t1_detect;

  always_comb begin
    // Two-flop synchronizers for the asynchronous request and ready inputs.
    hrq_meta_d    = hold_request;
    hrq_s_d       = hrq_meta_q;
    rdy_meta_d    = io_channel_ready;
    rdy_s_d       = rdy_meta_q;
    status_prev_d = processor_status;

    // A bus cycle starts on the first non-passive status after a passive one.
    t1_detect = (status_prev_q == c_status_passive) &&
                (processor_status != c_status_passive);

    // Wait counter: load on T1 even while the bus is granted away, so a cycle
    // begun under DMA is still stretched once the CPU gets the bus back.
    wait_count_d = wait_count_q;
    if (t1_detect) begin
      case (processor_status)
        3'b000, 3'b001, 3'b010: wait_count_d = c_io_wait;
        3'b100, 3'b101, 3'b110: wait_count_d = c_mem_wait;
        default:                wait_count_d = 3'd0;
      endcase
    end else if (wait_count_q != 3'd0) begin
      wait_count_d = wait_count_q - 3'd1;
    end

    state_d       = state_q;
    setup_count_d = setup_count_q;
    case (state_q)
      ST_IDLE: begin
        if (hrq_s_q) state_d = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (!hrq_s_q) begin
          state_d = ST_IDLE;
        end else if ((processor_status == c_status_passive) && lock_n &&
                     (wait_count_q == 3'd0) && !t1_detect) begin
          state_d       = ST_RELEASE;
          setup_count_d = c_setup_cycles;
        end
      end
      ST_RELEASE: begin
        // Request withdrawal wins over an expiring setup count.
        if (!hrq_s_q) begin
          state_d = ST_RETURN;
        end else if (setup_count_q <= 3'd1) begin
          state_d = ST_GRANT;
        end else begin
          setup_count_d = setup_count_q - 3'd1;
        end
      end
      ST_GRANT: begin
        if (!hrq_s_q) state_d = ST_RETURN;
      end
      ST_RETURN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Enables are decoded from the next state so they register together with
    // it; only GRANT drives dma_enable_n low and GRANT never drives
    // address_enable_n low, so both can never be low at once.
    address_enable_n_d = !((state_d == ST_IDLE) || (state_d == ST_WAIT_IDLE));
    dma_enable_n_d     = (state_d != ST_GRANT);
    hold_acknowledge_d = (state_d == ST_GRANT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      hrq_meta_q         <= 1'b0;
      hrq_s_q            <= 1'b0;
      rdy_meta_q         <= 1'b1;
      rdy_s_q            <= 1'b1;
      status_prev_q      <= c_status_passive;
      wait_count_q       <= 3'd0;
      setup_count_q      <= 3'd0;
      address_enable_n_q <= 1'b0;
      dma_enable_n_q     <= 1'b1;
      hold_acknowledge_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      hrq_meta_q         <= hrq_meta_d;
      hrq_s_q            <= hrq_s_d;
      rdy_meta_q         <= rdy_meta_d;
      rdy_s_q            <= rdy_s_d;
      status_prev_q      <= status_prev_d;
      wait_count_q       <= wait_count_d;
      setup_count_q      <= setup_count_d;
      address_enable_n_q <= address_enable_n_d;
      dma_enable_n_q     <= dma_enable_n_d;
      hold_acknowledge_q <= hold_acknowledge_d;
    end
  end

  assign address_enable_n = address_enable_n_q;
  assign dma_enable_n     = dma_enable_n_q;
  assign hold_acknowledge = hold_acknowledge_q;
  assign dma_ready        = rdy_s_q;
  assign cpu_ready        = (wait_count_q == 3'd0) && rdy_s_q &&
                            ((state_q == ST_IDLE) || (state_q == ST_WAIT_IDLE));

endmodule
`default_nettype wire

// File: tb/tb_dma_hold_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_hold_controller
//  Description : Self-checking bench for dma_hold_controller. Two instances
//                (default parameters, and IO=3/MEM=2/SETUP=3) share stimulus
//                and are compared every cycle against a bus-ownership model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_hold_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] processor_status = 3'b111;
  logic       lock_n = 1'b1;
  logic       hold_request = 1'b0;
  logic       io_channel_ready = 1'b1;
  logic [1:0] hlda, ae_n, den_n, crdy, drdy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  dma_hold_controller #(.IO_WAIT_STATES(1), .MEM_WAIT_STATES(0), .HOLD_SETUP_CYCLES(1)) dut (
    .clock(clock), .reset(reset), .processor_status(processor_status), .lock_n(lock_n),
    .hold_request(hold_request), .io_channel_ready(io_channel_ready),
    .hold_acknowledge(hlda[0]), .address_enable_n(ae_n[0]), .dma_enable_n(den_n[0]),
    .cpu_ready(crdy[0]), .dma_ready(drdy[0]));

  dma_hold_controller #(.IO_WAIT_STATES(3), .MEM_WAIT_STATES(2), .HOLD_SETUP_CYCLES(3)) dut3 (
    .clock(clock), .reset(reset), .processor_status(processor_status), .lock_n(lock_n),
    .hold_request(hold_request), .io_channel_ready(io_channel_ready),
    .hold_acknowledge(hlda[1]), .address_enable_n(ae_n[1]), .dma_enable_n(den_n[1]),
    .cpu_ready(crdy[1]), .dma_ready(drdy[1]));

  // ---------------- reference model ----------------
  // Ownership phases of the bus, from the CPU's point of view.
  localparam int CPU_OWNS = 0, CPU_PENDING = 1, HANDING_OVER = 2, DMA_OWNS = 3, HANDING_BACK = 4;
  int m_io[2]  = '{1, 3};
  int m_mem[2] = '{0, 2};
  int m_hsc[2] = '{1, 3};
  int m_phase[2] = '{0, 0};
  int m_spent[2] = '{0, 0};   // cycles already spent handing over
  int m_wait[2]  = '{0, 0};
  bit m_hq[2][2];             // [instance][pipeline position], index 1 = synchronized
  bit m_rq[2][2];
  logic [2:0] m_prev = 3'b111;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_hq[i] = '{1'b0, 1'b0};
      m_rq[i] = '{1'b1, 1'b1};
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_phase[i] = CPU_OWNS; m_spent[i] = 0; m_wait[i] = 0;
        m_hq[i] = '{1'b0, 1'b0}; m_rq[i] = '{1'b1, 1'b1};
      end
      m_prev = 3'b111;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (m_phase[i])
          CPU_OWNS:     if (m_hq[i][1]) m_phase[i] = CPU_PENDING;
          CPU_PENDING:  if (!m_hq[i][1]) m_phase[i] = CPU_OWNS;
                        else if (processor_status == 3'b111 && lock_n && m_wait[i] == 0) begin
                          m_phase[i] = HANDING_OVER; m_spent[i] = 0;
                        end
          HANDING_OVER: if (!m_hq[i][1]) m_phase[i] = HANDING_BACK;
                        else begin
                          m_spent[i]++;
                          if (m_spent[i] >= m_hsc[i]) m_phase[i] = DMA_OWNS;
                        end
          DMA_OWNS:     if (!m_hq[i][1]) m_phase[i] = HANDING_BACK;
          default:      m_phase[i] = CPU_OWNS;
        endcase
        if (m_prev == 3'b111 && processor_status != 3'b111)
          m_wait[i] = (processor_status == 3'b011) ? 0 :
                      (processor_status < 3'b011) ? m_io[i] : m_mem[i];
        else if (m_wait[i] > 0)
          m_wait[i]--;
        m_hq[i][1] = m_hq[i][0]; m_hq[i][0] = hold_request;
        m_rq[i][1] = m_rq[i][0]; m_rq[i][0] = io_channel_ready;
      end
      m_prev = processor_status;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ae_n[%0d]", i),  ae_n[i],  (m_phase[i] >= HANDING_OVER) ? 1 : 0);
      chk($sformatf("den_n[%0d]", i), den_n[i], (m_phase[i] == DMA_OWNS) ? 0 : 1);
      chk($sformatf("hlda[%0d]", i),  hlda[i],  (m_phase[i] == DMA_OWNS) ? 1 : 0);
      chk($sformatf("cpu_ready[%0d]", i), crdy[i],
          (m_wait[i] == 0 && m_rq[i][1] && m_phase[i] < HANDING_OVER) ? 1 : 0);
      chk($sformatf("dma_ready[%0d]", i), drdy[i], m_rq[i][1]);
      chk($sformatf("enables_exclusive[%0d]", i), ae_n[i] | den_n[i], 1);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      check_all();
    end
  endtask

  initial begin
    int low;
    bit seen;

    // Reset values
    step(3);
    chk("rst_ae_n", ae_n, 2'b00);
    chk("rst_den_n", den_n, 2'b11);
    chk("rst_cpu_ready", crdy, 2'b11);
    reset = 1'b0;
    step(2);

    // Grant latency: RELEASE after edge 4, grant after edge 4+setup
    hold_request = 1'b1;
    step(4);
    chk("grant_e4_release", ae_n[0], 1);
    chk("grant_e4_hlda", hlda[0], 0);
    step(1);
    chk("grant_e5_hlda", hlda[0], 1);
    chk("grant_e5_den_n", den_n[0], 0);
    step(2);
    chk("grant_e7_hlda3", hlda[1], 1);

    // Asynchronous reset mid-GRANT, checked with no clock edge
    #3 reset = 1'b1;
    #1;
    chk("async_rst_ae_n", ae_n, 2'b00);
    chk("async_rst_den_n", den_n, 2'b11);
    chk("async_rst_hlda", hlda, 2'b00);
    hold_request = 1'b0;
    step(2);
    reset = 1'b0;
    step(2);
    chk("post_rst_idle", hlda, 2'b00);

    // Grant, then release sequence
    hold_request = 1'b1;
    step(8);
    chk("regrant", hlda, 2'b11);
    hold_request = 1'b0;
    step(2);
    chk("rel_e2_still_granted", hlda, 2'b11);
    step(1);
    chk("rel_e3_hlda", hlda, 2'b00);
    chk("rel_e3_den_n", den_n, 2'b11);
    chk("rel_e3_ae_n", ae_n, 2'b11);
    step(1);
    chk("rel_e4_ae_n", ae_n, 2'b00);

    // I/O read: one wait state on the default instance
    processor_status = 3'b001;
    step(1);
    chk("io_ws_low", crdy[0], 0);
    step(1);
    chk("io_ws_high", crdy[0], 1);
    processor_status = 3'b111;
    step(3);

    // Memory read with zero wait states never drops cpu_ready
    processor_status = 3'b101;
    low = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (crdy[0] == 1'b0) low++;
      if (i == 1) processor_status = 3'b111;
    end
    chk("mem_ws0_low_cycles", low, 0);
    step(3);

    // Locked bus blocks the handover
    lock_n = 1'b0;
    hold_request = 1'b1;
    step(22);
    chk("lock_wait_ae_n", ae_n, 2'b00);
    chk("lock_wait_hlda", hlda, 2'b00);
    lock_n = 1'b1;
    step(1);
    chk("unlock_release", ae_n, 2'b11);
    step(1);
    chk("unlock_grant_hsc1", hlda[0], 1);
    step(2);
    chk("unlock_grant_hsc3", hlda[1], 1);
    hold_request = 1'b0;
    step(5);

    // Request withdrawn during RELEASE on the setup=3 instance
    hold_request = 1'b1;
    step(4);
    chk("drop_in_release", ae_n[1], 1);
    hold_request = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (hlda[1]) seen = 1'b1;
    end
    chk("drop_return_ae_n", ae_n[1], 1);
    step(1);
    chk("drop_idle_ae_n", ae_n[1], 0);
    chk("drop_never_granted", seen, 0);
    step(3);

    // I/O cycle stretched by io_channel_ready low for 4 cycles
    processor_status = 3'b001;
    io_channel_ready = 1'b0;
    low = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (crdy[0] == 1'b0) low++;
      if (i == 1) processor_status = 3'b111;
      if (i == 3) io_channel_ready = 1'b1;
    end
    chk("rdy_extend_low_cycles", low, 5);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 11) == 0) hold_request = ~hold_request;
      lock_n = ($urandom_range(0, 7) != 0);
      io_channel_ready = ($urandom_range(0, 9) != 0);
      processor_status = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 6)) : 3'b111;
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_hold_controller.md
# dma_hold_controller

Sequences ownership of the system bus between the 8088 CPU and the 8237 DMA controller, and generates CPU wait states. It takes the DMA hold request, waits for an idle, unlocked CPU bus, and hands the bus to DMA. It then drives the bus-ownership enables consumed by the bus arbiter (CPU address enable, DMA enable, hold acknowledge) and later returns the bus to the CPU. It also inserts programmable I/O and memory wait states through the CPU READY line.

## Interface
- IO_WAIT_STATES, 1, wait states added to I/O read/write and INTA cycles (0-7)
- MEM_WAIT_STATES, 0, wait states added to memory read/write and code fetch cycles (0-7)
- HOLD_SETUP_CYCLES, 1, cycles between CPU bus release and DMA grant (1-7)

- clock  in  1  system clock, one period = one CPU T-state, rising-edge
- reset  in  1  reset, asynchronous, active-high
- processor_status  in  3  8088 S2:S0; 3'b111 = passive
- lock_n  in  1  CPU LOCK, low = bus locked
- hold_request  in  1  HRQ from 8237, asynchronous
- io_channel_ready  in  1  external I/O channel ready, asynchronous
- hold_acknowledge  out  1  HLDA to 8237
- address_enable_n  out  1  low = CPU owns address/command bus
- dma_enable_n  out  1  low = DMA owns address bus
- cpu_ready  out  1  READY to CPU, low inserts wait states
- dma_ready  out  1  READY to 8237

## Operation
- Synchronizers:
  - hold_request and io_channel_ready each pass through two flops, giving hrq_s and rdy_s.
  - dma_ready = rdy_s.
- Cycle detection:
  - status_prev is registered from processor_status each cycle.
  - T1 is detected when status_prev==3'b111 and processor_status!=3'b111.
- Wait counter (3 bits):
  - On T1 it loads IO_WAIT_STATES for status 000/001/010, MEM_WAIT_STATES for 100/101/110, and 0 for 011 (halt).
  - Otherwise it decrements while nonzero and saturates at 0.
- cpu_ready = (wait_count==0) & rdy_s & (state==IDLE or WAIT_IDLE). The term is combinational from registers.
- FSM states: IDLE, WAIT_IDLE, RELEASE, GRANT, RETURN.
  - IDLE: address_enable_n=0, dma_enable_n=1, hold_acknowledge=0. Moves to WAIT_IDLE when hrq_s=1.
  - WAIT_IDLE: outputs as IDLE.
    - Moves to IDLE if hrq_s=0.
    - Otherwise moves to RELEASE when processor_status==3'b111, lock_n==1, wait_count==0 and no T1 is detected this cycle.
  - RELEASE: address_enable_n=1, dma_enable_n=1, hold_acknowledge=0, cpu_ready=0. A setup counter loads HOLD_SETUP_CYCLES on entry.
    - Moves to RETURN if hrq_s=0.
    - Otherwise moves to GRANT when the setup counter expires, after HOLD_SETUP_CYCLES cycles in RELEASE.
  - GRANT: address_enable_n=1, dma_enable_n=0, hold_acknowledge=1, cpu_ready=0. Moves to RETURN when hrq_s=0.
  - RETURN: address_enable_n=1, dma_enable_n=1, hold_acknowledge=0, cpu_ready=0. Moves to IDLE unconditionally after one cycle.
- Invariant: address_enable_n and dma_enable_n are never both 0. This holds on every cycle, including reset.
- A CPU cycle that starts during RELEASE/GRANT/RETURN still loads the wait counter. That cycle is held by cpu_ready=0 and completes after return to IDLE.

## Timing
- Reset values:
  - state=IDLE, address_enable_n=0, dma_enable_n=1, hold_acknowledge=0.
  - cpu_ready=1 once rdy_s settles. Synchronizers reset to 1 for ready and 0 for HRQ, so cpu_ready=1 and dma_ready=1 immediately.
  - wait_count=0, status_prev=3'b111.
- All state and output flops are registered. FSM outputs are decoded from the state register with no combinational path from the inputs.
- Grant latency, with bus passive and unlocked and hold_request rising before edge 1:
  - edge1: sync stage 1 captures hold_request.
  - edge2: hrq_s=1.
  - edge3: state=WAIT_IDLE.
  - edge4: state=RELEASE.
  - Edge 4+HOLD_SETUP_CYCLES: state=GRANT and hold_acknowledge=1 (edge5 with the default).
- Release latency: hold_request falls before edge1 → edge3 RETURN (hold_acknowledge=0, dma_enable_n=1) → edge4 IDLE (address_enable_n=0).
- Wait states: T1 at edge n loads the count. cpu_ready is low for exactly N cycles after edge n, sampled in T3, and extends while rdy_s=0.
- lock_n=0 or a nonzero wait_count blocks WAIT_IDLE→RELEASE indefinitely.
- hold_request toggled for less than 2 cycles may be missed; no grant is required for such a pulse.
- Asynchronous reset mid-GRANT forces the reset values immediately, with no RETURN cycle.

## Test plan
- Reset asserted in GRANT → address_enable_n=0, dma_enable_n=1, hold_acknowledge=0 with no clock edge; state IDLE after release.
- Bus passive, hold_request 0→1 → hold_acknowledge=1 after edge5 and dma_enable_n=0 on the same edge; hold_request 1→0 → address_enable_n=0 after edge4 of the release sequence.
- I/O read (status 001 after 111), IO_WAIT_STATES=1, rdy ready → cpu_ready low exactly 1 cycle; memory read with MEM_WAIT_STATES=0 → cpu_ready never low.
- hold_request held high with lock_n=0 for 20 cycles → state stays WAIT_IDLE, hold_acknowledge=0; lock_n→1 with passive status → hold_acknowledge=1 HOLD_SETUP_CYCLES+1 edges later.
- hold_request drops during RELEASE (HOLD_SETUP_CYCLES=3) → RETURN then IDLE, and hold_acknowledge never asserts.
- io_channel_ready low for 4 cycles during an I/O cycle → cpu_ready extended by 4 cycles (plus 2-cycle sync lag); dma_ready follows rdy_s. Check both enables never low together across all tests.
